// File: rtl/writeback.sv
// Writeback stage: selects ALU result, load data or call return address and registers it for the register file.
// Optional macro WB_FWD_EN exposes the pre-register select result as a same-cycle bypass.
module writeback #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4,
    parameter int RA_IDX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] ldresult,
    input  logic [DATA_W-1:0] aluresult,
    input  logic [31:0]       instruction,
    input  logic              is_wb,
    input  logic              is_call,
    input  logic              is_ld,
    output logic [DATA_W-1:0] data_out,
    output logic [REG_AW-1:0] rd_out,
`ifdef WB_FWD_EN
    output logic              is_wb_out,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [DATA_W-1:0] fwd_data
`else
    output logic              is_wb_out
`endif
);

    logic [DATA_W-1:0] sel_data;
    logic [REG_AW-1:0] sel_rd;
    logic [DATA_W-1:0] data_d, data_q;
    logic [REG_AW-1:0] rd_d, rd_q;
    logic              wb_d, wb_q;

    // Call outranks load; the pc+4 wraps naturally at DATA_W bits.
    always_comb begin
        sel_data = aluresult;
        sel_rd   = instruction[22 +: REG_AW];
        if (is_call) begin
            sel_data = pc + DATA_W'(4);
            sel_rd   = REG_AW'(RA_IDX);
        end else if (is_ld) begin
            sel_data = ldresult;
        end
    end

    // Flush beats stall: the bubble still captures data/rd but drops the write enable.
    always_comb begin
        data_d = data_q;
        rd_d   = rd_q;
        wb_d   = wb_q;
        if (flush) begin
            data_d = sel_data;
            rd_d   = sel_rd;
            wb_d   = 1'b0;
        end else if (!stall) begin
            data_d = sel_data;
            rd_d   = sel_rd;
            wb_d   = is_wb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            rd_q   <= '0;
            wb_q   <= 1'b0;
        end else begin
            data_q <= data_d;
            rd_q   <= rd_d;
            wb_q   <= wb_d;
        end
    end

    assign data_out  = data_q;
    assign rd_out    = rd_q;
    assign is_wb_out = wb_q;

`ifdef WB_FWD_EN
    assign fwd_valid = is_wb & ~flush;
    assign fwd_rd    = sel_rd;
    assign fwd_data  = sel_data;
`endif

endmodule

// File: tb/tb_writeback.sv
// Self-checking bench for writeback: directed spec cases plus randomized traffic against a queue-free behavioural model.
module tb_writeback;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic [31:0] pc, ldresult, aluresult, instruction;
    logic        is_wb, is_call, is_ld;
    logic [31:0] data_out;
    logic [3:0]  rd_out;
    logic        is_wb_out;
`ifdef WB_FWD_EN
    logic        fwd_valid;
    logic [3:0]  fwd_rd;
    logic [31:0] fwd_data;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_data;
    logic [3:0]  exp_rd;
    logic        exp_wb;

    always #5 clk = ~clk;

    writeback dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .pc(pc), .ldresult(ldresult), .aluresult(aluresult), .instruction(instruction),
        .is_wb(is_wb), .is_call(is_call), .is_ld(is_ld),
        .data_out(data_out), .rd_out(rd_out),
`ifdef WB_FWD_EN
        .is_wb_out(is_wb_out),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`else
        .is_wb_out(is_wb_out)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic [31:0] d, input logic [3:0] r, input logic w);
        n_cmp++;
        if (data_out !== d || rd_out !== r || is_wb_out !== w) begin
            n_err++;
            $display("FAIL %s: got data=%h rd=%0d wb=%b, want data=%h rd=%0d wb=%b",
                     name, data_out, rd_out, is_wb_out, d, r, w);
        end
    endtask

    // Reference: what the stage should commit, from the instruction-level rules.
    function automatic logic [35:0] ref_select(input logic [31:0] p, input logic [31:0] ld,
                                               input logic [31:0] alu, input logic [31:0] ins,
                                               input logic call, input logic load);
        logic [31:0] d;
        logic [3:0]  r;
        longint      ret;
        ret = (longint'(p) + 4) % 64'h1_0000_0000;
        r = 4'((ins >> 22) & 32'hF);
        if (call) begin
            d = 32'(ret);
            r = 4'd15;
        end else if (load) d = ld;
        else d = alu;
        return {r, d};
    endfunction

    task automatic idle_inputs();
        stall = 0; flush = 0; pc = 0; ldresult = 0; aluresult = 0; instruction = 0;
        is_wb = 0; is_call = 0; is_ld = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        aluresult = 32'h1234_5678; is_wb = 1; instruction = 32'h03C0_0000;
        tick();
        check_out("reset_held", 32'h0, 4'h0, 1'b0);
        rst = 0;
    endtask

    task automatic test_alu();
        idle_inputs();
        instruction = 32'h0100_0000; aluresult = 32'hAABB_CCDD; is_wb = 1;
`ifdef WB_FWD_EN
        #1;
        n_cmp++;
        if (fwd_data !== 32'hAABB_CCDD || fwd_rd !== 4'd4 || fwd_valid !== 1'b1) begin
            n_err++;
            $display("FAIL fwd_alu: got data=%h rd=%0d v=%b, want aabbccdd 4 1", fwd_data, fwd_rd, fwd_valid);
        end
        flush = 1;
        #1;
        n_cmp++;
        if (fwd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL fwd_flush: got v=%b, want 0", fwd_valid);
        end
        flush = 0;
`endif
        tick();
        check_out("alu", 32'hAABB_CCDD, 4'd4, 1'b1);
    endtask

    task automatic test_load();
        idle_inputs();
        instruction = 32'h0100_0000; ldresult = 32'hCAFE_BABE; aluresult = 32'hDEAD_DEAD;
        is_ld = 1; is_wb = 1;
        tick();
        check_out("load", 32'hCAFE_BABE, 4'd4, 1'b1);
    endtask

    task automatic test_call();
        idle_inputs();
        pc = 32'h30; is_call = 1; is_ld = 1; is_wb = 1;
        instruction = 32'h0100_0000; ldresult = 32'h1111_1111; aluresult = 32'h2222_2222;
        tick();
        check_out("call", 32'h34, 4'd15, 1'b1);
        pc = 32'hFFFF_FFFC;
        tick();
        check_out("call_wrap", 32'h0, 4'd15, 1'b1);
        is_wb = 0;
        tick();
        check_out("call_no_wb", 32'h0, 4'd15, 1'b0);
    endtask

    task automatic test_stall_flush();
        idle_inputs();
        instruction = 32'h0280_0000; aluresult = 32'h5555_AAAA; is_wb = 1;
        tick();
        check_out("pre_stall", 32'h5555_AAAA, 4'd10, 1'b1);
        stall = 1; aluresult = 32'h0F0F_0F0F; instruction = 32'h0040_0000; is_wb = 0;
        tick();
        check_out("stall_hold", 32'h5555_AAAA, 4'd10, 1'b1);
        flush = 1;
        tick();
        check_out("stall_flush", 32'h0F0F_0F0F, 4'd1, 1'b0);
        stall = 0; flush = 0; is_wb = 1;
        tick();
        check_out("after_flush", 32'h0F0F_0F0F, 4'd1, 1'b1);
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        instruction = 32'h03C0_0000; aluresult = 32'h8765_4321; is_wb = 1;
        tick();
        check_out("pre_rst", 32'h8765_4321, 4'd15, 1'b1);
        #2;
        rst = 1;
        #1;
        check_out("rst_async", 32'h0, 4'h0, 1'b0);
        tick();
        check_out("rst_hold", 32'h0, 4'h0, 1'b0);
        #1;
        rst = 0;
        tick();
        check_out("rst_release", 32'h8765_4321, 4'd15, 1'b1);
    endtask

    task automatic test_random();
        logic [35:0] s;
        exp_data = data_out; exp_rd = rd_out; exp_wb = is_wb_out;
        for (int i = 0; i < 400; i++) begin
            pc          = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
            ldresult    = $urandom;
            aluresult   = $urandom;
            instruction = $urandom;
            is_wb       = 1'($urandom);
            is_call     = ($urandom_range(0, 3) == 0);
            is_ld       = 1'($urandom);
            stall       = ($urandom_range(0, 3) == 0);
            flush       = ($urandom_range(0, 5) == 0);
            s = ref_select(pc, ldresult, aluresult, instruction, is_call, is_ld);
            if (flush) begin
                exp_data = s[31:0]; exp_rd = s[35:32]; exp_wb = 1'b0;
            end else if (!stall) begin
                exp_data = s[31:0]; exp_rd = s[35:32]; exp_wb = is_wb;
            end
            tick();
            check_out($sformatf("rand%0d", i), exp_data, exp_rd, exp_wb);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_call();
        test_stall_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
